// File: rtl/axis_upsizer_8to32_if.sv
// AXI4-Stream bundle shared by the narrow input side and the wide output
// side of the upsizer. The width parameters are set per instance.
interface axis_upsizer_8to32_if #(
    parameter int DATA_W = 8,
    parameter int KEEP_W = 1
) ();

    logic              tvalid;
    logic              tready;
    logic [DATA_W-1:0] tdata;
    logic [KEEP_W-1:0] tkeep;

    // Source of a stream: drives payload and valid, receives ready.
    modport master (
        output tvalid,
        output tdata,
        output tkeep,
        input  tready
    );

    // Sink of a stream: the upsizer input side does not use tkeep, since
    // every accepted narrow beat is one full byte lane.
    modport slave (
        input  tvalid,
        input  tdata,
        output tready
    );

endinterface

// File: rtl/axis_upsizer_8to32.sv
// AXI4-Stream width upsizer: packs RATIO consecutive narrow beats into one
// wide word, little-endian (first accepted byte lands in the lowest lane).
// A registered one-entry output stage provides full backpressure, and a
// flush request emits the partially filled word with tkeep marking the
// valid lanes.
module axis_upsizer_8to32 #(
    parameter int S_DATA_WIDTH = 8,
    parameter int RATIO        = 4,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                 aclk,
    input  logic                 areset,
    input  logic                 flush,
    output logic                 pending,
    output logic [CNT_WIDTH-1:0] word_count,
    axis_upsizer_8to32_if.slave  s_axis,
    axis_upsizer_8to32_if.master m_axis
);

    localparam int M_DATA_WIDTH = S_DATA_WIDTH * RATIO;
    localparam int ACC_WIDTH    = S_DATA_WIDTH * (RATIO - 1);
    localparam int IDX_WIDTH    = $clog2(RATIO);
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(RATIO - 1);

    // Packing state: number of held bytes and the lanes below the last one.
    // The last lane never needs storage because it goes straight into the
    // output register together with the accumulated lanes.
    logic [IDX_WIDTH-1:0]    cnt_q, cnt_d;
    logic [ACC_WIDTH-1:0]    acc_q, acc_d;

    // One-entry output holding stage and the handshake counter.
    logic [M_DATA_WIDTH-1:0] tdata_q, tdata_d;
    logic [RATIO-1:0]        tkeep_q, tkeep_d;
    logic                    tvalid_q, tvalid_d;
    logic [CNT_WIDTH-1:0]    wordCount_q, wordCount_d;

    // Handshake qualifiers.
    logic outFree;
    logic sReady;
    logic inFire;
    logic flushLoad;
    logic outFire;

    // Decide which transfers happen this cycle. Ready is derived only from
    // registered state, flush, reset and downstream ready, never from the
    // input valid, so no combinational loop can form through a master that
    // waits for ready.
    always_comb begin
        outFree   = !tvalid_q || m_axis.tready;
        sReady    = !areset && !flush && ((cnt_q != LAST_IDX) || outFree);
        inFire    = s_axis.tvalid && sReady;
        flushLoad = flush && !areset && (cnt_q != '0) && outFree;
        outFire   = tvalid_q && m_axis.tready;
    end

    // Next-state: accumulate bytes, load the output stage on the last byte
    // or on a flush, and retire the output word when it is taken. A load in
    // the same cycle as a retire simply replaces the word, keeping valid high.
    always_comb begin
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        tdata_d     = tdata_q;
        tkeep_d     = tkeep_q;
        tvalid_d    = tvalid_q;
        wordCount_d = wordCount_q;

        if (outFire) begin
            tvalid_d    = 1'b0;
            wordCount_d = wordCount_q + 1'b1;
        end

        if (inFire) begin
            if (cnt_q == LAST_IDX) begin
                tdata_d  = {s_axis.tdata, acc_q};
                tkeep_d  = '1;
                tvalid_d = 1'b1;
                cnt_d    = '0;
                acc_d    = '0;
            end else begin
                for (int i = 0; i < RATIO - 1; i++) begin
                    if (cnt_q == IDX_WIDTH'(i)) begin
                        acc_d[i*S_DATA_WIDTH +: S_DATA_WIDTH] = s_axis.tdata;
                    end
                end
                cnt_d = cnt_q + 1'b1;
            end
        end else if (flushLoad) begin
            // Lanes at or above cnt are already zero because the
            // accumulator is cleared on every emit and filled in order.
            tdata_d = {{S_DATA_WIDTH{1'b0}}, acc_q};
            for (int i = 0; i < RATIO; i++) begin
                tkeep_d[i] = (IDX_WIDTH'(i) < cnt_q);
            end
            tvalid_d = 1'b1;
            cnt_d    = '0;
            acc_d    = '0;
        end
    end

    // State registers with synchronous reset; reset discards both the
    // partial word and any word still waiting in the output stage.
    always_ff @(posedge aclk) begin
        if (areset) begin
            cnt_q       <= '0;
            acc_q       <= '0;
            tdata_q     <= '0;
            tkeep_q     <= '0;
            tvalid_q    <= 1'b0;
            wordCount_q <= '0;
        end else begin
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            tdata_q     <= tdata_d;
            tkeep_q     <= tkeep_d;
            tvalid_q    <= tvalid_d;
            wordCount_q <= wordCount_d;
        end
    end

    assign s_axis.tready = sReady;
    assign m_axis.tvalid = tvalid_q;
    assign m_axis.tdata  = tdata_q;
    assign m_axis.tkeep  = tkeep_q;
    assign pending       = (cnt_q != '0);
    assign word_count    = wordCount_q;

endmodule

// File: tb/tb_axis_upsizer_8to32.sv
// Bench for the 8-to-32 upsizer: directed scenarios followed by random
// traffic. A byte-queue reference model predicts the emitted words and
// pushes them into a scoreboard; an independent monitor pops and compares
// whenever the output handshakes.
module tb_axis_upsizer_8to32;

    localparam int RATIO = 4;
    localparam int S_W   = 8;
    localparam int M_W   = S_W * RATIO;
    localparam int CNT_W = 4;

    typedef struct {
        logic [M_W-1:0]   data;
        logic [RATIO-1:0] keep;
    } ExpWord;

    logic             aclk = 1'b0;
    logic             areset;
    logic             flush;
    logic             pending;
    logic [CNT_W-1:0] word_count;

    axis_upsizer_8to32_if #(.DATA_W(S_W), .KEEP_W(1))     sIf ();
    axis_upsizer_8to32_if #(.DATA_W(M_W), .KEEP_W(RATIO)) mIf ();

    axis_upsizer_8to32 #(
        .S_DATA_WIDTH(S_W),
        .RATIO       (RATIO),
        .CNT_WIDTH   (CNT_W)
    ) dut (
        .aclk      (aclk),
        .areset    (areset),
        .flush     (flush),
        .pending   (pending),
        .word_count(word_count),
        .s_axis    (sIf),
        .m_axis    (mIf)
    );

    always #5 aclk = ~aclk;

    int           checks = 0;
    int           errors = 0;
    ExpWord       expQ[$];
    logic [7:0]   heldBytes[$];
    logic [CNT_W-1:0] expCount = '0;
    bit           lastAccepted = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=0x%08h required=0x%08h", name, actual, expected);
        end
    endtask

    task automatic recordFail(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: actual=timeout required=completion", name);
    endtask

    // Turn the held bytes into the word the design should emit.
    task automatic emitHeld();
        ExpWord w;
        w.data = '0;
        w.keep = '0;
        foreach (heldBytes[i]) begin
            w.data    = w.data | (32'(heldBytes[i]) << (8 * i));
            w.keep[i] = 1'b1;
        end
        expQ.push_back(w);
        heldBytes.delete();
    endtask

    // Reference model step, evaluated mid-cycle while inputs are stable.
    task automatic modelStep();
        bit outFree;
        bit expReady;
        if (areset) begin
            heldBytes.delete();
            lastAccepted = 1'b0;
        end else begin
            outFree  = !mIf.tvalid || mIf.tready;
            expReady = !flush && ((heldBytes.size() != RATIO - 1) || outFree);
            checkOutput("s_tready", 32'(sIf.tready), 32'(expReady));
            checkOutput("pending", 32'(pending), 32'(heldBytes.size() != 0));
            lastAccepted = sIf.tvalid && sIf.tready;
            if (flush && heldBytes.size() > 0 && outFree) begin
                emitHeld();
            end else if (lastAccepted) begin
                heldBytes.push_back(sIf.tdata);
                if (heldBytes.size() == RATIO) emitHeld();
            end
        end
    endtask

    task automatic applyStimulus(input bit rst, input bit v, input logic [7:0] d,
                                 input bit fl, input bit rdy);
        @(posedge aclk);
        #1;
        areset     = rst;
        sIf.tvalid = v;
        sIf.tdata  = d;
        flush      = fl;
        mIf.tready = rdy;
        @(negedge aclk);
        modelStep();
    endtask

    task automatic sendByte(input logic [7:0] d, input bit rdy, output int attempts);
        attempts = 0;
        do begin
            applyStimulus(1'b0, 1'b1, d, 1'b0, rdy);
            attempts++;
        end while (!lastAccepted && attempts < 50);
        if (!lastAccepted) recordFail("send_timeout");
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, rdy);
    endtask

    // Output monitor: word_count tracking, AXI stability under stall and
    // scoreboard comparison on every output handshake.
    logic             stallPrev = 1'b0;
    logic [M_W-1:0]   prevData;
    logic [RATIO-1:0] prevKeep;

    always @(negedge aclk) begin : monitor
        ExpWord w;
        if (areset) begin
            expQ.delete();
            expCount  = '0;
            stallPrev = 1'b0;
        end else begin
            checkOutput("word_count", 32'(word_count), 32'(expCount));
            if (stallPrev) begin
                checkOutput("stall_tvalid", 32'(mIf.tvalid), 32'd1);
                checkOutput("stall_tdata", mIf.tdata, prevData);
                checkOutput("stall_tkeep", 32'(mIf.tkeep), 32'(prevKeep));
            end
            if (mIf.tvalid && mIf.tready) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_word: actual=0x%08h required=none", mIf.tdata);
                end else begin
                    w = expQ.pop_front();
                    checkOutput("m_tdata", mIf.tdata, w.data);
                    checkOutput("m_tkeep", 32'(mIf.tkeep), 32'(w.keep));
                end
                expCount = expCount + 1'b1;
            end
            stallPrev = mIf.tvalid && !mIf.tready;
            prevData  = mIf.tdata;
            prevKeep  = mIf.tkeep;
        end
    end

    // Global bound so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int att;
        int n;
        logic [7:0] wb;

        areset     = 1'b1;
        flush      = 1'b0;
        sIf.tvalid = 1'b0;
        sIf.tdata  = '0;
        sIf.tkeep  = 1'b1;
        mIf.tready = 1'b0;

        // Reset state.
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("rst_tvalid", 32'(mIf.tvalid), 32'd0);
        checkOutput("rst_tdata", mIf.tdata, 32'h0);
        checkOutput("rst_tkeep", 32'(mIf.tkeep), 32'h0);
        checkOutput("rst_word_count", 32'(word_count), 32'd0);
        checkOutput("rst_pending", 32'(pending), 32'd0);
        checkOutput("rst_s_tready", 32'(sIf.tready), 32'd0);

        // Single word and its one-cycle latency.
        sendByte(8'h11, 1'b1, att);
        sendByte(8'h22, 1'b1, att);
        sendByte(8'h33, 1'b1, att);
        sendByte(8'h44, 1'b1, att);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        checkOutput("latency_tvalid", 32'(mIf.tvalid), 32'd1);
        checkOutput("first_tdata", mIf.tdata, 32'h44332211);
        idle(2, 1'b1);
        checkOutput("first_word_count", 32'(word_count), 32'd1);

        // Continuous stream with no throttling.
        for (int i = 0; i < 16; i++) begin
            sendByte(8'(i), 1'b1, att);
            checkOutput("stream_no_stall", 32'(att), 32'd1);
        end
        idle(2, 1'b1);
        checkOutput("stream_word_count", 32'(word_count), 32'd5);

        // Backpressure: full word held, next three bytes accepted, fourth stalls.
        sendByte(8'h11, 1'b0, att);
        sendByte(8'h22, 1'b0, att);
        sendByte(8'h33, 1'b0, att);
        sendByte(8'h44, 1'b0, att);
        sendByte(8'h55, 1'b0, att);
        sendByte(8'h66, 1'b0, att);
        sendByte(8'h77, 1'b0, att);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, 8'h88, 1'b0, 1'b0);
            checkOutput("bp_s_tready", 32'(sIf.tready), 32'd0);
            checkOutput("bp_tdata_hold", mIf.tdata, 32'h44332211);
        end
        sendByte(8'h88, 1'b1, att);
        idle(3, 1'b1);
        checkOutput("bp_word_count", 32'(word_count), 32'd7);

        // Flush of a two-byte partial word, then flush with nothing held.
        sendByte(8'hAA, 1'b1, att);
        sendByte(8'hBB, 1'b1, att);
        n = 0;
        do begin
            applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
            n++;
        end while (pending && n < 20);
        if (pending) recordFail("flush_timeout");
        checkOutput("flush_tdata", mIf.tdata, 32'h0000BBAA);
        checkOutput("flush_tkeep", 32'(mIf.tkeep), 32'h3);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        checkOutput("empty_flush_no_word", 32'(mIf.tvalid), 32'd0);
        idle(1, 1'b1);
        checkOutput("flush_word_count", 32'(word_count), 32'd8);

        // Reset mid-operation with a word waiting and two bytes held.
        for (int i = 1; i <= 6; i++) sendByte(8'(i), 1'b0, att);
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("midrst_tvalid", 32'(mIf.tvalid), 32'd0);
        checkOutput("midrst_pending", 32'(pending), 32'd0);
        checkOutput("midrst_word_count", 32'(word_count), 32'd0);
        sendByte(8'hA1, 1'b1, att);
        sendByte(8'hA2, 1'b1, att);
        sendByte(8'hA3, 1'b1, att);
        sendByte(8'hA4, 1'b1, att);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        checkOutput("midrst_clean_word", mIf.tdata, 32'hA4A3A2A1);
        idle(2, 1'b1);

        // word_count wrap at 2^CNT_W handshakes.
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        for (int w = 0; w < 16; w++) begin
            for (int b = 0; b < 4; b++) begin
                wb = 8'($urandom);
                sendByte(wb, 1'b1, att);
            end
            idle(2, 1'b1);
            if (w == 14) checkOutput("wrap_before", 32'(word_count), 32'd15);
            if (w == 15) checkOutput("wrap_to_zero", 32'(word_count), 32'd0);
        end

        // Random traffic with random backpressure and occasional flush.
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(1'b0, ($urandom % 4) != 0, 8'($urandom),
                          ($urandom % 24) == 0, ($urandom % 3) != 0);
        end
        idle(10, 1'b1);
        checkOutput("scoreboard_drained", 32'(expQ.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
